// File: rtl/pipeline_perf_counter.sv
// Performance monitor for the 5-stage pipeline: cycles, load-use stalls,
// branch flushes, retired instructions and longest stall run, with a
// snapshot bank read back through a registered select port.

// Saturating event counter lane with sticky overflow.
// nxt_o / ovf_nxt_o expose the post-event, pre-clear value so the snapshot
// bank can capture this cycle's events even when a clear lands with it.
module pipeline_perf_counter_sat #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] nxt_o,
  output logic         ovf_nxt_o
);
  logic [W-1:0] cnt_q;
  logic         ovf_q;

  // Increment unless already at all-ones; an increment at all-ones sets the sticky flag.
  always_comb begin
    nxt_o     = cnt_q;
    ovf_nxt_o = ovf_q;
    if (inc_i) begin
      if (cnt_q == '1) ovf_nxt_o = 1'b1;
      else             nxt_o     = cnt_q + 1'b1;
    end
  end

  // Clear beats the same-cycle event.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= nxt_o;
      ovf_q <= ovf_nxt_o;
    end
  end
endmodule

module pipeline_perf_counter #(
  parameter int CNT_W = 32,
  parameter int SEL_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             freeze_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic             snap_i,
  input  logic             rd_en_i,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             running_o
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam int NEV = 4;                    // cyc, stall, flush, retire
  localparam int FW  = (CNT_W < 5) ? CNT_W : 5;

  state_t state;
  logic   in_run;

  logic [NEV-1:0]            ev;
  logic [NEV-1:0][CNT_W-1:0] cnt_nx;
  logic [NEV-1:0]            ovf_nx;

  logic [CNT_W-1:0] run_q, run_nx, max_q, max_nx;
  logic             run_ovf_q, run_ovf_nx;

  logic [4:0]       flags_nx;
  logic [CNT_W-1:0] flag_word;
  logic [CNT_W-1:0] snap_q [6];

  logic [1:0]       vld_pipe;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] rd_mux;

  // Control FSM; running_o is registered alongside the state it reflects.
  // Dropping start_i takes priority over freeze_i in RUN and HOLD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      running_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state     <= RUN;
          running_o <= 1'b1;
        end
        RUN: if (!start_i) begin
          state     <= IDLE;
          running_o <= 1'b0;
        end else if (freeze_i) begin
          state     <= HOLD;
          running_o <= 1'b0;
        end
        HOLD: if (!start_i) begin
          state     <= IDLE;
          running_o <= 1'b0;
        end else if (!freeze_i) begin
          state     <= RUN;
          running_o <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          running_o <= 1'b0;
        end
      endcase
    end
  end

  // Events only count in a cycle whose current state is RUN.
  assign in_run = (state == RUN);
  assign ev     = in_run ? {retire_i, flush_i, stall_i & ~branch_i, 1'b1} : '0;

  generate
    for (genvar g = 0; g < NEV; g++) begin : g_cnt
      pipeline_perf_counter_sat #(.W(CNT_W)) u_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (clear_i),
        .inc_i     (ev[g]),
        .nxt_o     (cnt_nx[g]),
        .ovf_nxt_o (ovf_nx[g])
      );
    end
  endgenerate

  // Stall run: grows on a counted stall, restarts on any other RUN cycle,
  // frozen outside RUN. max_run compares against the incremented run.
  always_comb begin
    run_nx     = run_q;
    max_nx     = max_q;
    run_ovf_nx = run_ovf_q;
    if (ev[1]) begin
      if (run_q == '1) run_ovf_nx = 1'b1;
      else             run_nx     = run_q + 1'b1;
      if (run_nx > max_q) max_nx = run_nx;
    end else if (in_run) begin
      run_nx = '0;
    end
  end

  // Run tracking registers; clear beats the same-cycle stall.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      run_q     <= '0;
      max_q     <= '0;
      run_ovf_q <= 1'b0;
    end else begin
      run_q     <= run_nx;
      max_q     <= max_nx;
      run_ovf_q <= run_ovf_nx;
    end
  end

  // Overflow flags packed into the low bits of a counter-wide word.
  assign flags_nx = {run_ovf_nx, ovf_nx};
  always_comb begin
    flag_word          = '0;
    flag_word[FW-1:0]  = flags_nx[FW-1:0];
  end

  // Snapshot bank captures post-event, pre-clear values; clear_i never touches it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 6; i++) snap_q[i] <= '0;
    end else if (snap_i) begin
      for (int i = 0; i < NEV; i++) snap_q[i] <= cnt_nx[i];
      snap_q[4] <= max_nx;
      snap_q[5] <= flag_word;
    end
  end

  // Read select; unused selects return zero.
  always_comb begin
    case (sel_q)
      SEL_W'(0): rd_mux = snap_q[0];
      SEL_W'(1): rd_mux = snap_q[1];
      SEL_W'(2): rd_mux = snap_q[2];
      SEL_W'(3): rd_mux = snap_q[3];
      SEL_W'(4): rd_mux = snap_q[4];
      SEL_W'(5): rd_mux = snap_q[5];
      default:   rd_mux = '0;
    endcase
  end

  // Two-stage read: capture the request, then read the bank one edge later
  // so a snapshot taken with the request is the one returned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      sel_q     <= '0;
      rd_data_o <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_en_i};
      if (rd_en_i)     sel_q     <= rd_sel_i;
      if (vld_pipe[0]) rd_data_o <= rd_mux;
    end
  end

  assign rd_valid_o = vld_pipe[1];
endmodule

// File: tb/tb_pipeline_perf_counter.sv
// Bench for pipeline_perf_counter: a 32-bit and a 4-bit instance share stimulus.
// Reads push expected data onto a scoreboard queue; a negedge monitor pops
// and compares whenever rd_valid_o shows up.
module tb_pipeline_perf_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, freeze, stall, branch, flush, retire, clear, snap, rd_en;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [3:0]  rd_data4;
  logic        rd_valid, rd_valid4, running, running4;

  pipeline_perf_counter #(.CNT_W(32), .SEL_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .stall_i(stall),
    .branch_i(branch), .flush_i(flush), .retire_i(retire), .clear_i(clear), .snap_i(snap),
    .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .running_o(running));

  pipeline_perf_counter #(.CNT_W(4), .SEL_W(3)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .stall_i(stall),
    .branch_i(branch), .flush_i(flush), .retire_i(retire), .clear_i(clear), .snap_i(snap),
    .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_data_o(rd_data4), .rd_valid_o(rd_valid4),
    .running_o(running4));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp;
    logic [3:0]  exp4;
    int          due;
    string       name;
  } rd_t;
  rd_t sbq[$];

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read this cycle; response expected after the second edge.
  task automatic rd(input int sel, input logic [31:0] e, input logic [3:0] e4, input string name);
    rd_t r;
    r.exp = e; r.exp4 = e4; r.due = cyc + 2; r.name = name;
    sbq.push_back(r);
    rd_en  = 1'b1;
    rd_sel = 3'(sel);
    tick();
  endtask

  always @(negedge clk) begin
    if (rd_valid || rd_valid4) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=%0b/%0b expected no read pending", rd_valid, rd_valid4);
      end else begin
        rd_t r;
        r = sbq.pop_front();
        check({r.name, "_data"}, rd_data, r.exp);
        check({r.name, "_data4"}, {28'd0, rd_data4}, {28'd0, r.exp4});
        checks++;
        if (!(rd_valid && rd_valid4) || cyc != r.due) begin
          errors++;
          $display("FAIL %s_timing: got valid=%0b/%0b at cycle %0d expected both at cycle %0d",
                   r.name, rd_valid, rd_valid4, cyc, r.due);
        end
      end
    end
  end

  initial begin
    vec_t t1 [7];
    logic [7:0] pat;
    t1[0] = '{0, 32'd10, "t1_cyc"};
    t1[1] = '{1, 32'd3,  "t1_stall"};
    t1[2] = '{2, 32'd2,  "t1_flush"};
    t1[3] = '{3, 32'd5,  "t1_retire"};
    t1[4] = '{4, 32'd3,  "t1_maxrun"};
    t1[5] = '{5, 32'd0,  "t1_flags"};
    t1[6] = '{3, 32'd5,  "t1_retire_again"};

    {start, freeze, stall, branch, flush, retire, clear, snap, rd_en} = '0;
    rd_sel = '0;
    rst = 1'b1;
    tick(); tick();
    check("rst_data", rd_data, 32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    rst = 1'b0;

    // 1: basic counting, stall with branch suppressed, table of reads
    start = 1'b1;
    tick();
    check("t1_running", {31'd0, running}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      stall  = (k < 4);
      branch = (k == 3);
      flush  = (k == 4 || k == 5);
      retire = (k >= 5);
      snap   = (k == 9);
      tick();
    end
    {stall, branch, flush, retire, snap} = '0;
    start = 1'b0;
    for (int i = 0; i < 7; i++) rd(t1[i].sel, t1[i].exp, t1[i].exp[3:0], t1[i].name);
    rd_en = 1'b0;
    tick(); tick();
    check("t1_valid_drop", {31'd0, rd_valid}, 32'd0);
    check("t1_data_hold", rd_data, 32'd5);
    check("t1_idle", {31'd0, running}, 32'd0);

    // 2: stall run pattern, then freeze for 4 cycles
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick();
    pat = 8'b10111011;
    for (int i = 0; i < 8; i++) begin
      stall = pat[i];
      tick();
    end
    stall  = 1'b0;
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_frozen_running", {31'd0, running}, 32'd0);
    end
    freeze = 1'b0;
    tick();
    check("t2_resume_running", {31'd0, running}, 32'd1);
    tick();
    snap = 1'b1; tick(); snap = 1'b0;
    rd(0, 32'd11, 4'd11, "t2_cyc");
    rd(1, 32'd6, 4'd6, "t2_stall");
    rd(4, 32'd3, 4'd3, "t2_maxrun");
    rd(5, 32'd0, 4'd0, "t2_flags");
    rd_en = 1'b0;

    // 3: 20 RUN cycles saturate the 4-bit instance; clear restarts it
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (19) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    rd(0, 32'd20, 4'd15, "t3_cyc_sat");
    rd(5, 32'd0, 4'd1, "t3_flags_sat");
    rd_en = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    tick(); tick();
    snap = 1'b1; tick(); snap = 1'b0;
    rd(0, 32'd3, 4'd3, "t3_cyc_restart");
    rd(5, 32'd0, 4'd0, "t3_flags_cleared");
    rd_en = 1'b0;

    // 4: clear + snap + stall + read all in one cycle
    clear = 1'b1; tick(); clear = 1'b0;
    stall = 1'b1; tick(); tick();
    clear = 1'b1; snap = 1'b1;
    rd(1, 32'd3, 4'd3, "t4_snap_preclear");
    clear = 1'b0; stall = 1'b0;
    rd(1, 32'd0, 4'd0, "t4_live_cleared");
    snap = 1'b0;
    rd(0, 32'd1, 4'd1, "t4_cyc_after");
    rd(4, 32'd0, 4'd0, "t4_maxrun_after");
    rd_en = 1'b0;
    tick();

    // 5: reset mid-run with a read request
    rd(0, 32'd1, 4'd1, "t5_pre_reset");
    rd_en = 1'b0;
    tick(); tick();
    rst = 1'b1; rd_en = 1'b1; rd_sel = 3'd0; start = 1'b0;
    tick();
    check("t5_rst_data", rd_data, 32'd0);
    check("t5_rst_valid", {31'd0, rd_valid}, 32'd0);
    check("t5_rst_running", {31'd0, running}, 32'd0);
    rst = 1'b0; rd_en = 1'b0;
    stall = 1'b1; retire = 1'b1;
    repeat (3) tick();
    check("t5_idle_running", {31'd0, running}, 32'd0);
    snap = 1'b1;
    rd(0, 32'd0, 4'd0, "t5_cyc_idle");
    snap = 1'b0;
    rd(3, 32'd0, 4'd0, "t5_retire_idle");
    rd(1, 32'd0, 4'd0, "t5_stall_idle");
    rd_en = 1'b0; stall = 1'b0; retire = 1'b0;
    tick();

    // 6: start drop returns to IDLE and holds counters; out-of-range selects
    start = 1'b1; tick();
    repeat (4) tick();
    start = 1'b0; tick();
    check("t6_stop_running", {31'd0, running}, 32'd0);
    stall = 1'b1; retire = 1'b1; flush = 1'b1;
    repeat (3) tick();
    snap = 1'b1;
    rd(0, 32'd5, 4'd5, "t6_cyc_held");
    snap = 1'b0; stall = 1'b0; retire = 1'b0; flush = 1'b0;
    rd(6, 32'd0, 4'd0, "t6_sel6");
    rd(0, 32'd5, 4'd5, "t6_cyc_again");
    rd(7, 32'd0, 4'd0, "t6_sel7");
    rd(3, 32'd0, 4'd0, "t6_retire_held");
    rd_en = 1'b0;
    tick(); tick();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d reads outstanding expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
